program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Host-side boot loader placed directly upstream of the Processor core. It takes a byte stream
//  from a UART receiver, assembles 32-bit words into an internal buffer, and replays each complete
//  segment to the core as an unbroken burst on inst_load/data_load/data, so pc_curr never runs
//  between words. It also owns the core reset (core_rst): the core is held in reset except during
//  a burst or after a RUN command.
// PARAMETERS
//  DEPTH      2048   word buffer depth; max words per segment (matches 11-bit core memories)
//  CMD_INST   8'hA5  header byte: instruction segment follows
//  CMD_DATA   8'h5A  header byte: data segment follows
//  CMD_RUN    8'hC3  release core from reset
//  CMD_STOP   8'hFF  return core to reset
// PORTS
//  clk          in   1   single clock, shared with the core
//  rst          in   1   asynchronous, active-low reset
//  rx_valid     in   1   one-cycle strobe: rx_data holds a new byte
//  rx_data      in   8   received byte
//  core_rst     out  1   active-high reset to the core's rst
//  inst_load    out  1   instruction-memory write strobe to the core
//  data_load    out  1   data-memory write strobe to the core
//  data         out  32  word written during a load cycle
//  running      out  1   core released by RUN
//  busy         out  1   segment reception or burst in progress
//  err          out  1   sticky error flag; cleared only by rst
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, buffer pointers=0, core_rst=1, all other outputs=0.
//  States: IDLE, CNT_LO, CNT_HI, PAYLOAD, BURST, RUN.
//  IDLE: acts on rx_valid bytes. CMD_INST/CMD_DATA latch the segment type -> CNT_LO.
//    CMD_RUN -> RUN. Any other byte, including CMD_STOP, is ignored.
//  CNT_LO/CNT_HI: 16-bit word count N, little-endian (low byte first).
//    N==0 -> IDLE, no error. N>DEPTH -> err=1, IDLE; the payload is not consumed.
//    Otherwise -> PAYLOAD.
//  PAYLOAD: 4*N bytes, each word little-endian (first byte = bits[7:0]). Each complete word is
//    pushed into the buffer. busy=1 from the first count byte until the end of the burst.
//  BURST: let T be the cycle of the final payload byte. During cycles T+2 .. T+1+N:
//    - core_rst=0;
//    - exactly one of inst_load/data_load (per the segment type) is 1;
//    - data = word k in cycle T+2+k.
//    In cycle T+2+N: load=0, core_rst=1, state=IDLE, busy=0, buffer pointers=0.
//    data, inst_load and data_load are registered outputs; data=0 whenever both loads are 0.
//  Because core_rst was high before the burst, the core pc starts at 0, so word k lands at
//    address k.
//  rx_valid in BURST: the byte is dropped and err=1.
//  RUN: core_rst=0 and running=1 starting the cycle after the CMD_RUN byte. CMD_STOP -> IDLE,
//    with core_rst=1 and running=0 the next cycle. All other bytes are ignored.
//  rx_valid is never back-pressured; only one byte is accepted per cycle.
//  Word count is unsigned 16-bit. The buffer index is clog2(DEPTH) bits and never wraps within a
//    segment.
//  rst asserted mid-payload or mid-burst aborts immediately: partial data is discarded, and
//    core_rst returns to 1 asynchronously.
// TESTING
//  1. A5,02,00, 13,00,00,20, 78,56,34,12 -> inst_load high for exactly 2 cycles, data=32'h20000013
//     then 32'h12345678, core_rst=0 in exactly those cycles, busy=0 afterwards.
//  2. 5A,01,00,EF,BE,AD,DE then C3 -> data_load 1 cycle with 32'hDEADBEEF; after C3,
//     core_rst=0 and running=1; after FF, core_rst=1 and running=0.
//  3. A5,00,00 -> no load pulses, err=0, IDLE. A5,01,08 (N=2049 > DEPTH) -> err=1, no load pulses.
//  4. N=DEPTH full segment with incrementing words -> DEPTH contiguous load cycles with data=0..
//     DEPTH-1, no gaps.
//  5. rx_valid asserted during a 4-word burst -> burst completes unchanged and err=1.
//  6. rst pulsed low after 5 of 8 payload bytes -> immediate reset values; a following 1-word
//     segment loads correctly.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and core-load bus of the program loader.
// The host side (UART receiver plus observers) uses master; the loader uses slave.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        core_rst;
    logic        inst_load;
    logic        data_load;
    logic [31:0] data;
    logic        running;
    logic        busy;
    logic        err;

    modport master (
        output rx_valid, rx_data,
        input  core_rst, inst_load, data_load, data, running, busy, err
    );

    modport slave (
        input  rx_valid, rx_data,
        output core_rst, inst_load, data_load, data, running, busy, err
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader that sits upstream of the processor core.
// Bytes from a UART receiver are assembled into 32-bit words and buffered.
// A complete segment is replayed to the core as one gap-free burst while the
// core is briefly out of reset, so the core pc walks 0..N-1 in step with the words.
// Outside a burst the core is held in reset unless a RUN command released it.
module program_loader #(
    parameter int         DEPTH    = 2048,
    parameter logic [7:0] CMD_INST = 8'hA5,
    parameter logic [7:0] CMD_DATA = 8'h5A,
    parameter logic [7:0] CMD_RUN  = 8'hC3,
    parameter logic [7:0] CMD_STOP = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    // Buffer index width; DEPTH is expected to be a power of two so the
    // index covers the buffer exactly.
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        PAYLOAD,
        BURST,
        RUN
    } state_t;

    state_t        state_reg;
    logic          seg_inst_reg;   // 1: instruction segment, 0: data segment
    logic [7:0]    cnt_lo_reg;     // low byte of the word count
    logic [AW:0]   n_words_reg;    // words in the current segment (1..DEPTH)
    logic [AW-1:0] wr_ptr_reg;     // next buffer slot to fill
    logic [AW-1:0] rd_ptr_reg;     // buffer slot being read for the burst
    logic [1:0]    byte_idx_reg;   // byte position inside the current word
    logic [AW:0]   ld_cnt_reg;     // load cycles already issued in this burst

    // Registered outputs
    logic          core_rst_reg;
    logic          inst_load_reg;
    logic          data_load_reg;
    logic [31:0]   data_reg;
    logic          running_reg;
    logic          busy_reg;
    logic          err_reg;

    // Word assembly / buffer signals
    logic [15:0]   cnt_full;
    logic          payload_byte;
    logic          push_word;
    logic [31:0]   wr_word;
    logic [AW:0]   wr_cnt_inc;
    logic          last_word;
    logic [31:0]   rd_word;

    assign cnt_full     = {bus.rx_data, cnt_lo_reg};
    assign payload_byte = (state_reg == PAYLOAD) && bus.rx_valid;
    assign push_word    = payload_byte && (byte_idx_reg == 2'd3);
    assign wr_cnt_inc   = {1'b0, wr_ptr_reg} + (AW+1)'(1);
    assign last_word    = push_word && (wr_cnt_inc == n_words_reg);

    // Byte lanes 0..2 hold the first three bytes of a word; the fourth byte is
    // taken straight from rx_data so the word is written on its final byte.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the byte that lands in this lane of the current word
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg <= '0;
                end else if (payload_byte && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= bus.rx_data;
                end
            end
        end
    endgenerate

    assign wr_word = {bus.rx_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

    // Word buffer: plain array with a registered read port so it maps to block RAM.
    logic [31:0] mem [DEPTH];
    logic [31:0] mem_q;
    logic        byp_hit_q;
    logic [31:0] byp_word_q;

    // Buffer write, registered read, and a one-entry bypass for the case where the
    // slot being read is written in the same cycle (a 1-word segment: word 0 is
    // written by the final payload byte exactly when slot 0 is first read).
    always_ff @(posedge clk) begin
        if (push_word) begin
            mem[wr_ptr_reg] <= wr_word;
        end
        mem_q      <= mem[rd_ptr_reg];
        byp_hit_q  <= push_word && (wr_ptr_reg == rd_ptr_reg);
        byp_word_q <= wr_word;
    end

    assign rd_word = byp_hit_q ? byp_word_q : mem_q;

    // Command/segment FSM with all core-facing outputs registered.
    // Burst timing: the final payload byte moves to BURST with slot 0 already
    // being read, so the first load cycle follows one cycle later and the
    // remaining words stream out one per cycle from the read pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            seg_inst_reg  <= 1'b0;
            cnt_lo_reg    <= '0;
            n_words_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            byte_idx_reg  <= '0;
            ld_cnt_reg    <= '0;
            core_rst_reg  <= 1'b1;
            inst_load_reg <= 1'b0;
            data_load_reg <= 1'b0;
            data_reg      <= '0;
            running_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if ((bus.rx_data == CMD_INST) || (bus.rx_data == CMD_DATA)) begin
                            seg_inst_reg <= (bus.rx_data == CMD_INST);
                            busy_reg     <= 1'b1;
                            state_reg    <= CNT_LO;
                        end else if (bus.rx_data == CMD_RUN) begin
                            running_reg  <= 1'b1;
                            core_rst_reg <= 1'b0;
                            state_reg    <= RUN;
                        end
                    end
                end

                CNT_LO: begin
                    if (bus.rx_valid) begin
                        cnt_lo_reg <= bus.rx_data;
                        state_reg  <= CNT_HI;
                    end
                end

                CNT_HI: begin
                    if (bus.rx_valid) begin
                        if (cnt_full == 16'd0) begin
                            // Empty segment: nothing to load, quietly back to idle
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else if ({1'b0, cnt_full} > DEPTH_W) begin
                            // Too large for the buffer; its payload is not consumed
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            n_words_reg  <= cnt_full[AW:0];
                            wr_ptr_reg   <= '0;
                            byte_idx_reg <= '0;
                            state_reg    <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (bus.rx_valid) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (push_word) begin
                            wr_ptr_reg <= wr_ptr_reg + AW'(1);
                        end
                        if (last_word) begin
                            // Slot 0 is read on this edge; continue from slot 1
                            rd_ptr_reg <= AW'(1);
                            ld_cnt_reg <= '0;
                            state_reg  <= BURST;
                        end
                    end
                end

                BURST: begin
                    // Bytes cannot be accepted while replaying; flag the loss
                    if (bus.rx_valid) begin
                        err_reg <= 1'b1;
                    end
                    if (ld_cnt_reg == n_words_reg) begin
                        inst_load_reg <= 1'b0;
                        data_load_reg <= 1'b0;
                        data_reg      <= '0;
                        core_rst_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        inst_load_reg <= seg_inst_reg;
                        data_load_reg <= !seg_inst_reg;
                        data_reg      <= rd_word;
                        core_rst_reg  <= 1'b0;
                        ld_cnt_reg    <= ld_cnt_reg + (AW+1)'(1);
                        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                    end
                end

                RUN: begin
                    if (bus.rx_valid && (bus.rx_data == CMD_STOP)) begin
                        running_reg  <= 1'b0;
                        core_rst_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_reg;
    assign bus.inst_load = inst_load_reg;
    assign bus.data_load = data_load_reg;
    assign bus.data      = data_reg;
    assign bus.running   = running_reg;
    assign bus.busy      = busy_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed scenarios plus randomized byte streams,
// every cycle checked against a behavioural model of the loader's rules.
module tb_program_loader;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    program_loader_if bus_if();

    program_loader #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CLO, M_CHI, M_PAY, M_BURST, M_RUN} mphase_t;

    mphase_t     m_phase;
    bit          m_inst;
    bit          m_run;
    bit          m_err;
    int          m_cnt_lo;
    int          m_n;
    int          m_bytes;
    logic [31:0] m_cur;
    logic [31:0] m_words[$];
    int          m_burst_start;
    int          edge_n = 0;

    // loads observed on the DUT outputs
    logic [31:0] seen[$];
    bit          seen_inst[$];
    logic [31:0] tx_words[$];

    function automatic void m_reset();
        m_phase       = M_IDLE;
        m_inst        = 1'b0;
        m_run         = 1'b0;
        m_err         = 1'b0;
        m_cnt_lo      = 0;
        m_n           = 0;
        m_bytes       = 0;
        m_cur         = '0;
        m_burst_start = 0;
        m_words.delete();
    endfunction

    // One clock edge of the loader's rules: the byte present at the edge is
    // acted on, and a burst whose last load cycle just ended returns to idle.
    function automatic void model_step(logic v, logic [7:0] b);
        edge_n++;
        if (v) begin
            case (m_phase)
                M_IDLE: begin
                    if (b == 8'hA5 || b == 8'h5A) begin
                        m_inst = (b == 8'hA5);
                        m_words.delete();
                        m_phase = M_CLO;
                    end else if (b == 8'hC3) begin
                        m_run = 1'b1;
                        m_phase = M_RUN;
                    end
                end
                M_CLO: begin
                    m_cnt_lo = int'(b);
                    m_phase = M_CHI;
                end
                M_CHI: begin
                    m_n = int'(b) * 256 + m_cnt_lo;
                    if (m_n == 0) begin
                        m_phase = M_IDLE;
                    end else if (m_n > DEPTH) begin
                        m_err = 1'b1;
                        m_phase = M_IDLE;
                    end else begin
                        m_bytes = 0;
                        m_cur = '0;
                        m_phase = M_PAY;
                    end
                end
                M_PAY: begin
                    m_cur = m_cur | (32'(b) << (8 * (m_bytes % 4)));
                    m_bytes++;
                    if (m_bytes % 4 == 0) begin
                        m_words.push_back(m_cur);
                        m_cur = '0;
                    end
                    if (m_bytes == 4 * m_n) begin
                        m_phase = M_BURST;
                        m_burst_start = edge_n + 1;
                    end
                end
                M_BURST: m_err = 1'b1;
                M_RUN: begin
                    if (b == 8'hFF) begin
                        m_run = 1'b0;
                        m_phase = M_IDLE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
        if (m_phase == M_BURST && edge_n >= m_burst_start + m_n)
            m_phase = M_IDLE;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else      model_step(bus_if.rx_valid, bus_if.rx_data);
        end
    end

    // ---------------- checking ----------------
    function automatic void check1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
        end
    endfunction

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [31:0] seen_at(int i);
        if (i < seen.size()) return seen[i];
        return 32'hxxxxxxxx;
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bit          in_b;
                logic [31:0] exp_data;
                in_b = (m_phase == M_BURST) && (edge_n >= m_burst_start) &&
                       (edge_n < m_burst_start + m_n);
                exp_data = in_b ? m_words[edge_n - m_burst_start] : 32'h0;
                check1 ("cyc_inst_load", bus_if.inst_load, in_b && m_inst);
                check1 ("cyc_data_load", bus_if.data_load, in_b && !m_inst);
                check32("cyc_data",      bus_if.data,      exp_data);
                check1 ("cyc_core_rst",  bus_if.core_rst,  !(in_b || m_run));
                check1 ("cyc_running",   bus_if.running,   m_run);
                check1 ("cyc_busy",      bus_if.busy,
                        m_phase inside {M_CLO, M_CHI, M_PAY, M_BURST});
                check1 ("cyc_err",       bus_if.err,       m_err);
                if (bus_if.inst_load || bus_if.data_load) begin
                    seen.push_back(bus_if.data);
                    seen_inst.push_back(bus_if.inst_load);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        $display("byte %02h accepted at edge %0d", b, edge_n);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic gap_send(logic [7:0] b, int max_gap);
        if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        send_byte(b);
    endtask

    // Header, count and payload; incr selects words 0,1,2.. instead of random
    task automatic send_seg(bit inst, int n, int max_gap, bit incr);
        logic [31:0] word;
        tx_words.delete();
        send_byte(inst ? 8'hA5 : 8'h5A);
        gap_send(8'(n), max_gap);
        gap_send(8'(n >> 8), max_gap);
        for (int w = 0; w < n; w++) begin
            word = incr ? 32'(w) : $urandom();
            tx_words.push_back(word);
            for (int k = 0; k < 4; k++) gap_send(word[8*k +: 8], max_gap);
        end
    endtask

    // Async reset asserted mid-cycle; outputs must take reset values at once
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check1 ("rst_core_rst",  bus_if.core_rst,  1'b1);
        check1 ("rst_inst_load", bus_if.inst_load, 1'b0);
        check1 ("rst_data_load", bus_if.data_load, 1'b0);
        check32("rst_data",      bus_if.data,      32'h0);
        check1 ("rst_running",   bus_if.running,   1'b0);
        check1 ("rst_busy",      bus_if.busy,      1'b0);
        check1 ("rst_err",       bus_if.err,       1'b0);
        seen.delete();
        seen_inst.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] q[$];
        int good;
        int r;
        int n;
        logic [7:0] junk;

        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // 1: two-word instruction segment
        do_reset();
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h78, 8'h56, 8'h34, 8'h12};
        send_q(q);
        idle(6);
        check32("t1_count", 32'(seen.size()), 32'd2);
        check32("t1_w0", seen_at(0), 32'h20000013);
        check32("t1_w1", seen_at(1), 32'h12345678);
        check1 ("t1_inst", seen_inst.size() > 0 && seen_inst[0], 1'b1);
        check1 ("t1_busy", bus_if.busy, 1'b0);
        check1 ("t1_core_rst", bus_if.core_rst, 1'b1);

        // 2: one-word data segment, then RUN and STOP
        do_reset();
        q = '{8'h5A, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q(q);
        idle(4);
        check32("t2_count", 32'(seen.size()), 32'd1);
        check32("t2_w0", seen_at(0), 32'hDEADBEEF);
        check1 ("t2_data_seg", seen_inst.size() > 0 && !seen_inst[0], 1'b1);
        send_byte(8'hC3);
        check1 ("t2_run_core_rst", bus_if.core_rst, 1'b0);
        check1 ("t2_running", bus_if.running, 1'b1);
        idle(3);
        send_byte(8'hFF);
        check1 ("t2_stop_core_rst", bus_if.core_rst, 1'b1);
        check1 ("t2_stopped", bus_if.running, 1'b0);

        // 3: empty segment, then oversized segment, then a normal one
        do_reset();
        q = '{8'hA5, 8'h00, 8'h00};
        send_q(q);
        idle(3);
        check1 ("t3_zero_err", bus_if.err, 1'b0);
        check32("t3_zero_loads", 32'(seen.size()), 32'd0);
        check1 ("t3_zero_busy", bus_if.busy, 1'b0);
        q = '{8'hA5, 8'h01, 8'h08};
        send_q(q);
        idle(3);
        check1 ("t3_big_err", bus_if.err, 1'b1);
        check32("t3_big_loads", 32'(seen.size()), 32'd0);
        q = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_q(q);
        idle(4);
        check32("t3_after_w0", seen_at(0), 32'h04030201);

        // 4: full-depth segment of incrementing words
        do_reset();
        send_seg(1'b1, DEPTH, 0, 1'b1);
        idle(DEPTH + 4);
        check32("t4_count", 32'(seen.size()), 32'(DEPTH));
        good = 0;
        foreach (seen[i]) if (seen[i] === 32'(i)) good++;
        check32("t4_incr_words", 32'(good), 32'(DEPTH));

        // 5: byte arriving during a 4-word burst is dropped and flagged
        do_reset();
        send_seg(1'b0, 4, 0, 1'b0);
        send_byte(8'hC3);
        idle(8);
        check1 ("t5_err", bus_if.err, 1'b1);
        check1 ("t5_not_running", bus_if.running, 1'b0);
        check32("t5_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) check32("t5_word", seen_at(i), tx_words[i]);

        // 6: reset after 5 of 8 payload bytes, then a clean 1-word segment
        do_reset();
        q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_q(q);
        do_reset();
        q = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_q(q);
        idle(4);
        check32("t6_count", 32'(seen.size()), 32'd1);
        check32("t6_w0", seen_at(0), 32'hCAFEF00D);

        // Randomized traffic, checked each cycle against the model
        do_reset();
        for (int it = 0; it < 120; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                do junk = 8'($urandom_range(0, 255));
                while (junk == 8'hA5 || junk == 8'h5A || junk == 8'hC3);
                send_byte(junk);
            end else if (r < 18) begin
                send_byte(8'hC3);
                repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 254)));
                idle(int'($urandom_range(0, 2)));
                send_byte(8'hFF);
            end else if (r < 22) begin
                n = int'($urandom_range(DEPTH + 1, 65535));
                send_byte(r[0] ? 8'hA5 : 8'h5A);
                send_byte(8'(n));
                send_byte(8'(n >> 8));
            end else begin
                n = int'($urandom_range(0, 8));
                send_seg(r[0], n, 2, 1'b0);
                if ($urandom_range(0, 9) == 0) begin
                    send_byte(8'($urandom_range(0, 255)));
                    idle(n + 3);
                end else begin
                    idle(n + 2 + int'($urandom_range(0, 2)));
                end
            end
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
